// File: rtl/add_slice_sched.sv
// add_slice_sched
//   Shares one external 2-bit adder slice between two requesters. A W-bit
//   add (a + b + cin) is accepted over a valid/ready handshake, sequenced
//   through the slice two bits per cycle from LSB to MSB, and returned
//   with its carry-out and requester ID over a valid/ready response port.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   reqX_valid/ready            request handshake for requester X (0/1)
//   reqX_a, reqX_b, reqX_cin    W-bit operands and carry-in
//   rsp_valid/ready             response handshake
//   rsp_id, rsp_sum, rsp_cout   owning requester, W-bit sum, carry out
//   sl_a, sl_b, sl_cin          digit and carry driven into the slice
//   sl_z, sl_cout               slice result (combinational from sl_*)
module add_slice_sched #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_cin,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_cin,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_sum,
    output logic         rsp_cout,
    output logic [1:0]   sl_a,
    output logic [1:0]   sl_b,
    output logic         sl_cin,
    input  logic [1:0]   sl_z,
    input  logic         sl_cout
);

    localparam int unsigned N  = W / 2;
    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;
    localparam logic [SW-1:0] LAST = SW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q;
    logic [W-1:0]  a_q, b_q, sum_q, sum_d;
    logic          carry_q, id_q, lp_q;
    logic [SW-1:0] step_q;
    logic [W-1:0]  rsp_sum_q;
    logic          rsp_valid_q, rsp_cout_q, rsp_id_q;
    logic          gnt0, gnt1;
    logic [SW:0]   idx;

    // Round-robin: on contention the requester not served last wins.
    always_comb begin
        gnt0 = req0_valid && (!req1_valid || lp_q);
        gnt1 = req1_valid && (!req0_valid || !lp_q);
    end

    assign req0_ready = rst_n && (state_q == IDLE) && gnt0;
    assign req1_ready = rst_n && (state_q == IDLE) && gnt1;

    // Bit offset of the current digit.
    assign idx = {step_q, 1'b0};

    assign sl_a   = (state_q == RUN) ? a_q[idx +: 2] : '0;
    assign sl_b   = (state_q == RUN) ? b_q[idx +: 2] : '0;
    assign sl_cin = (state_q == RUN) ? carry_q : 1'b0;

    // Partial sum with this cycle's slice digit merged in; on the final
    // step this is the complete result.
    always_comb begin
        sum_d          = sum_q;
        sum_d[idx +: 2] = sl_z;
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            id_q        <= 1'b0;
            lp_q        <= 1'b1;
            step_q      <= '0;
            rsp_sum_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        a_q     <= gnt1 ? req1_a   : req0_a;
                        b_q     <= gnt1 ? req1_b   : req0_b;
                        carry_q <= gnt1 ? req1_cin : req0_cin;
                        id_q    <= gnt1;
                        lp_q    <= gnt1;
                        step_q  <= '0;
                        sum_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= sl_cout;
                    step_q  <= step_q + SW'(1);
                    if (step_q == LAST) begin
                        rsp_sum_q   <= sum_d;
                        rsp_cout_q  <= sl_cout;
                        rsp_id_q    <= id_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_slice_sched.sv
// Bench for add_slice_sched with a behavioural 2-bit slice. Expected
// responses are queued on acceptance and compared as they are consumed.
module tb_add_slice_sched;

    localparam int unsigned W = 8;
    localparam int unsigned N = W / 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_cin;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_cin;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_cout;
    logic [W-1:0] rsp_sum;
    logic [1:0]   sl_a, sl_b, sl_z;
    logic         sl_cin, sl_cout;

    always #5 clk = ~clk;

    add_slice_sched #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .sl_a       (sl_a),
        .sl_b       (sl_b),
        .sl_cin     (sl_cin),
        .sl_z       (sl_z),
        .sl_cout    (sl_cout)
    );

    // Behavioural 2-bit adder slice.
    assign {sl_cout, sl_z} = {1'b0, sl_a} + {1'b0, sl_b} + {2'b00, sl_cin};

    typedef struct packed {
        logic         id;
        logic [W-1:0] sum;
        logic         cout;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   n_rsp  = 0;
    int   n_exp  = 0;
    logic lp_m   = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Response monitor: compare every consumed response with the queue head.
    always @(negedge clk) begin
        #3;
        if (rst_n && rsp_valid && rsp_ready) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL rsp_unexpected: observed sum %0h id %0d, expected no response", rsp_sum, rsp_id);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_id",   rsp_id,   mon_e.id);
                chk("rsp_sum",  rsp_sum,  mon_e.sum);
                chk("rsp_cout", rsp_cout, mon_e.cout);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
        end
    endtask

    // Called just after a negedge with valids driven. Waits (bounded) for a
    // grant, checks it against the arbitration model, queues the expected
    // response and returns after the acceptance edge.
    task automatic accept(output logic g);
        int           n;
        logic [W-1:0] a, b;
        logic         c;
        logic [W:0]   s;
        rsp_t         e;
        n = 0;
        #1;
        while (!(req0_ready || req1_ready) && n < 40) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout: observed no ready, expected a grant");
            g = 1'b0;
            return;
        end
        if (req0_valid && req1_valid) g = !lp_m;
        else                          g = req1_valid;
        chk("req0_ready", req0_ready, !g);
        chk("req1_ready", req1_ready, g);
        a = g ? req1_a   : req0_a;
        b = g ? req1_b   : req0_b;
        c = g ? req1_cin : req0_cin;
        s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        e.id = g; e.sum = s[W-1:0]; e.cout = s[W];
        exp_q.push_back(e);
        n_exp++;
        lp_m = g;
        @(posedge clk);
    endtask

    // Full add from an IDLE negedge; checks slice sequencing and latency.
    task automatic do_add(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic       g, c;
        logic [1:0] da, db;
        logic [2:0] t;
        drive(id, a, b, cin);
        accept(g);
        c = cin;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
                req0_a = ~req0_a; req0_b = req0_b ^ 8'h5A; req0_cin = ~req0_cin;
                req1_a = ~req1_a; req1_b = req1_b ^ 8'hA5; req1_cin = ~req1_cin;
            end
            da = a[2*k +: 2];
            db = b[2*k +: 2];
            chk("sl_a", sl_a, da);
            chk("sl_b", sl_b, db);
            chk("sl_cin", sl_cin, c);
            chk("rsp_valid_run", rsp_valid, 1'b0);
            t = {1'b0, da} + {1'b0, db} + {2'b00, c};
            c = t[2];
        end
        @(negedge clk);
        chk("rsp_valid_at_5", rsp_valid, 1'b1);
        chk("sl_a_done", sl_a, 2'b00);
        if (rsp_ready) @(negedge clk);
    endtask

    logic g;

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'hAA; req0_b = 8'h55; req0_cin = 1'b1;
        req1_valid = 1'b1; req1_a = 8'h0F; req1_b = 8'hF0; req1_cin = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_sum", rsp_sum, 8'h00);
        chk("rst_rsp_cout", rsp_cout, 1'b0);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_sl_a", sl_a, 2'b00);
        chk("rst_sl_b", sl_b, 2'b00);
        chk("rst_sl_cin", sl_cin, 1'b0);
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_req1_ready", req1_ready, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;

        // Basic adds, including wrap-around.
        do_add(1'b0, 8'h5A, 8'h3C, 1'b0);
        do_add(1'b1, 8'hFF, 8'h01, 1'b0);
        do_add(1'b1, 8'h7F, 8'h80, 1'b1);

        // Contention right after reset, then sustained contention.
        rst_n = 1'b0; lp_m = 1'b1;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 8'h01, 8'h02, 1'b0);
        drive(1'b1, 8'h10, 8'h20, 1'b0);
        for (int i = 0; i < 4; i++) begin
            accept(g);
            for (int k = 0; k <= N; k++) begin
                @(negedge clk);
                chk("busy_req0_ready", req0_ready, 1'b0);
                chk("busy_req1_ready", req1_ready, 1'b0);
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Back-pressure in DONE with a competing request held.
        rsp_ready = 1'b0;
        drive(1'b0, 8'h33, 8'h44, 1'b1);
        accept(g);
        @(negedge clk);
        req0_valid = 1'b0;
        drive(1'b1, 8'h11, 8'h22, 1'b0);
        for (int k = 1; k < N; k++) @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("hold_rsp_valid", rsp_valid, 1'b1);
            chk("hold_rsp_sum", rsp_sum, 8'h78);
            chk("hold_rsp_cout", rsp_cout, 1'b0);
            chk("hold_rsp_id", rsp_id, 1'b0);
            chk("hold_req0_ready", req0_ready, 1'b0);
            chk("hold_req1_ready", req1_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("handshake_req1_ready", req1_ready, 1'b0);
        @(negedge clk);
        chk("after_hs_rsp_valid", rsp_valid, 1'b0);
        accept(g);
        @(negedge clk);
        req1_valid = 1'b0;
        for (int k = 0; k < N; k++) @(negedge clk);
        @(negedge clk);

        // Reset during RUN step 2 drops the in-flight add.
        drive(1'b0, 8'h12, 8'h34, 1'b0);
        accept(g);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 8'h0F, 8'h01, 1'b0);
        @(negedge clk);
        void'(exp_q.pop_back());
        n_exp--;
        lp_m = 1'b1;
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_rsp_sum", rsp_sum, 8'h00);
        chk("midrst_rsp_cout", rsp_cout, 1'b0);
        chk("midrst_rsp_id", rsp_id, 1'b0);
        chk("midrst_sl_a", sl_a, 2'b00);
        chk("midrst_sl_b", sl_b, 2'b00);
        chk("midrst_sl_cin", sl_cin, 1'b0);
        chk("midrst_req0_ready", req0_ready, 1'b0);
        rst_n = 1'b1;
        do_add(1'b0, 8'h0F, 8'h01, 1'b0);

        // Corner operands followed by a random sweep through req0.
        do_add(1'b0, 8'h00, 8'h00, 1'b0);
        do_add(1'b0, 8'hFF, 8'hFF, 1'b1);
        do_add(1'b0, 8'hFF, 8'h00, 1'b1);
        do_add(1'b0, 8'h80, 8'h80, 1'b0);
        do_add(1'b0, 8'h55, 8'hAA, 1'b1);
        for (int i = 0; i < 400; i++) begin
            do_add(1'b0, W'($urandom), W'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("rsp_count", n_rsp, n_exp);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
